// File: rtl/sixtyfour_bit_serial_addsub.sv
// 64-bit add/subtract unit processing SLICE_W bits per cycle, LSB slice first.
// Operands are latched on start; S/Cout/V are valid while done is high and after.
module sixtyfour_bit_serial_addsub #(
  parameter int unsigned SLICE_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        sub,
  input  logic [63:0] A,
  input  logic [63:0] B,
  input  logic        Cin,
  output logic        busy,
  output logic        done,
  output logic [63:0] S,
  output logic        Cout,
  output logic        V
);

  localparam int unsigned NSLICE = 64 / SLICE_W;
  localparam int unsigned KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int unsigned SW1    = SLICE_W + 1;
  localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic              load_c;
  logic              last_c;
  logic [63:0]       a_q;
  logic [63:0]       b_q;
  logic              c_q;
  logic [KW-1:0]     k_q;
  logic [5:0]        lsb_c;
  logic [SLICE_W-1:0] a_sl_c;
  logic [SLICE_W-1:0] b_sl_c;
  logic [SLICE_W:0]  sum_c;
  logic              msb_cin_c;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; start is only honoured outside RUN
  always_comb begin
    state_next = state;
    load_c     = 1'b0;
    last_c     = (k_q == K_LAST);
    case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          load_c     = 1'b1;
        end
      end
      RUN: begin
        if (last_c) state_next = DONE;
      end
      DONE: begin
        if (start) begin
          state_next = RUN;
          load_c     = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Slice adder; carry into the slice MSB recovered from the sum bit for V
  always_comb begin
    lsb_c     = 6'(32'(k_q) * SLICE_W);
    a_sl_c    = a_q[lsb_c +: SLICE_W];
    b_sl_c    = b_q[lsb_c +: SLICE_W];
    sum_c     = {1'b0, a_sl_c} + {1'b0, b_sl_c} + SW1'(c_q);
    msb_cin_c = a_sl_c[SLICE_W-1] ^ b_sl_c[SLICE_W-1] ^ sum_c[SLICE_W-1];
  end

  // Datapath and registered status outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q  <= '0;
      b_q  <= '0;
      c_q  <= 1'b0;
      k_q  <= '0;
      S    <= '0;
      Cout <= 1'b0;
      V    <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_next == RUN);
      done <= (state_next == DONE);
      if (load_c) begin
        a_q <= A;
        b_q <= sub ? ~B : B;
        c_q <= sub ? 1'b1 : Cin;
        k_q <= '0;
      end else if (state == RUN) begin
        S[lsb_c +: SLICE_W] <= sum_c[SLICE_W-1:0];
        c_q                 <= sum_c[SLICE_W];
        if (last_c) begin
          Cout <= sum_c[SLICE_W];
          V    <= msb_cin_c ^ sum_c[SLICE_W];
        end else begin
          k_q <= k_q + KW'(1);
        end
      end
    end
  end

endmodule

// File: doc/sixtyfour_bit_serial_addsub.md
SIXTYFOUR_BIT_SERIAL_ADDSUB -- requirements
Module: sixtyfour_bit_serial_addsub

Interface
REQ-001 The block SHALL have parameter SLICE_W, default 16, meaning operand bits processed per RUN cycle; legal values 8, 16, 32, 64 (must divide 64).
REQ-002 The block SHALL derive NSLICE = 64/SLICE_W as a localparam, meaning the number of RUN cycles per operation.
REQ-003 The block SHALL have port clk  input  1  rising-edge clock; the only clock.
REQ-004 The block SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 The block SHALL have port start  input  1  operation request, sampled on rising clk.
REQ-006 The block SHALL have port sub  input  1  operation select, 0 = add, 1 = subtract; sampled with start.
REQ-007 The block SHALL have port A  input  64  first operand; sampled with start.
REQ-008 The block SHALL have port B  input  64  second operand; sampled with start.
REQ-009 The block SHALL have port Cin  input  1  carry-in for add; ignored when sub=1; sampled with start.
REQ-010 The block SHALL have port busy  output  1  high while an operation is in progress (state RUN).
REQ-011 The block SHALL have port done  output  1  one-cycle pulse marking S/Cout/V valid.
REQ-012 The block SHALL have port S  output  64  registered result.
REQ-013 The block SHALL have port Cout  output  1  registered carry-out of bit 63; for sub, 1 = no borrow (A >= B unsigned).
REQ-014 The block SHALL have port V  output  1  registered two's-complement overflow flag.

Function
REQ-015 The block SHALL implement states IDLE, RUN, DONE; busy = (state==RUN); done = (state==DONE).
REQ-016 In IDLE or DONE, start=1 SHALL latch A, B' = sub ? ~B : B, and c = sub ? 1 : Cin; clear slice counter to 0; go to RUN.
REQ-017 In RUN, each cycle SHALL add slice k of A and B' plus c, write the SLICE_W-bit sum into S[k*SLICE_W +: SLICE_W], update c with the slice carry-out, increment k.
REQ-018 Slices SHALL be processed LSB first; k SHALL count 0..NSLICE-1 without wrap within one operation.
REQ-019 On the RUN cycle with k==NSLICE-1, the block SHALL register Cout = final carry, V = carry into bit 63 XOR carry out of bit 63, and go to DONE.
REQ-020 Latency: start sampled at edge t SHALL give done=1 for exactly the cycle following edge t+NSLICE (t+4 for SLICE_W=16).
REQ-021 DONE SHALL last exactly one cycle, then go to IDLE unless start=1 (REQ-016), giving back-to-back throughput of one result per NSLICE+1 cycles.
REQ-022 start asserted while in RUN SHALL be ignored; latched operands SHALL not change.
REQ-023 S, Cout, V SHALL hold their last value in IDLE until the next operation's RUN cycles overwrite them; S bits are undefined-valid during RUN (partial) and only meaningful while done=1 or later in IDLE.
REQ-024 Arithmetic SHALL be modulo 2^64; no saturation; all operands treated as raw 64-bit vectors.
REQ-025 With SLICE_W=64, the block SHALL complete RUN in one cycle (NSLICE=1) with identical semantics.

Reset
REQ-026 On a rising clk with rst_n=0, the block SHALL enter IDLE and set S=0, Cout=0, V=0, busy=0, done=0, k=0, internal carry=0.
REQ-027 Reset asserted during RUN or DONE SHALL abort the operation with no done pulse; rst_n SHALL override start in the same cycle.
REQ-028 No output SHALL change asynchronously to clk.

Verification
REQ-029 Add: A=0, B=0xAAAAAAAAAAAAAAAA, Cin=0, sub=0 -> done after 4 RUN cycles, S=0xAAAAAAAAAAAAAAAA, Cout=0, V=0.
REQ-030 Add carry chain: A=B=0xFFFFFFFFFFFFFFFF, Cin=0 -> S=0xFFFFFFFFFFFFFFFE, Cout=1, V=0; same with Cin=1 -> S=0xFFFFFFFFFFFFFFFF, Cout=1, V=0.
REQ-031 Subtract borrow: A=0, B=1, sub=1, Cin=1 (ignored) -> S=0xFFFFFFFFFFFFFFFF, Cout=0, V=0; A=5, B=3, sub=1 -> S=2, Cout=1.
REQ-032 Overflow: A=0x7FFFFFFFFFFFFFFF, B=1, sub=0, Cin=0 -> S=0x8000000000000000, V=1, Cout=0; A=0x8000000000000000, B=1, sub=1 -> S=0x7FFFFFFFFFFFFFFF, V=1, Cout=1.
REQ-033 Handshake: start held high for 10 cycles with changing A -> busy high 4 cycles, done pulses on cycles 5 and 10, each result uses A sampled at its accepted start only.
REQ-034 Reset mid-op: rst_n=0 for one cycle at RUN k=2 -> next cycle busy=0, done=0, S=0, Cout=0, V=0, and no done pulse follows; bench checks every done against a 65-bit reference model.
